// File: rtl/hilo_bypass_file_pkg.sv
// Shared constants and helpers for the HI/LO register file and its pending tracker.
// Also defines the forwarding-slice macro HILO_FWD_LSB used to index packed stage data.
`ifndef HILO_FWD_LSB
`define HILO_FWD_LSB(idx, width) ((idx) * (width))
`endif

package hilo_bypass_file_pkg;

    localparam int HILO_DATA_W = 32;

    // Largest count a PEND_W-bit pending counter may hold.
    function automatic int hilo_pend_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/hilo_bypass_file_pend_tracker.sv
// Outstanding MDU operation counter with saturation, flush and a sticky protocol-error flag.
module hilo_pend_tracker
    import hilo_bypass_file_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mdu_start,
    input  logic              mdu_done,
    input  logic              flush,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              pend_err
);

    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(hilo_pend_max(PEND_W));

    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (flush) begin
            cnt_d = '0;
        end else if (mdu_start && !mdu_done) begin
            if (cnt_q == CNT_MAX) err_d = 1'b1;
            else                  cnt_d = cnt_q + PEND_W'(1);
        end else if (mdu_done && !mdu_start) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign pend_cnt = cnt_q;
    assign pend_err = err_q;

endmodule

// File: rtl/hilo_bypass_file.sv
// HI/LO special-register file with priority forwarding and MDU stall generation.
// Optional HILO_ACC_EN adds MADD/MSUB-style accumulate on commit.
module hilo_bypass_file
    import hilo_bypass_file_pkg::*;
#(
    parameter int DATA_WIDTH = HILO_DATA_W,
    parameter int FWD_STAGES = 2,
    parameter int PEND_W     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FWD_STAGES-1:0]            fwd_hi_en,
    input  logic [FWD_STAGES-1:0]            fwd_lo_en,
    input  logic [FWD_STAGES*DATA_WIDTH-1:0] fwd_hi_data,
    input  logic [FWD_STAGES*DATA_WIDTH-1:0] fwd_lo_data,
    input  logic                             commit_hi_en,
    input  logic                             commit_lo_en,
    input  logic [DATA_WIDTH-1:0]            commit_hi_data,
    input  logic [DATA_WIDTH-1:0]            commit_lo_data,
`ifdef HILO_ACC_EN
    input  logic                             commit_acc,
    input  logic                             commit_sub,
`endif
    input  logic                             mdu_start,
    input  logic                             mdu_done,
    input  logic                             flush,
    input  logic                             rd_req,
    output logic [DATA_WIDTH-1:0]            hi_rdata,
    output logic [DATA_WIDTH-1:0]            lo_rdata,
    output logic                             stall_req,
    output logic                             pend_err
);

    logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_WIDTH-1:0] hi_cval, lo_cval;
    logic [PEND_W-1:0]     pend_cnt;

`ifdef HILO_ACC_EN
    logic [2*DATA_WIDTH-1:0] acc_sum;

    // Carry/borrow crosses from LO into HI because the sum is one 2W-bit quantity.
    always_comb begin
        acc_sum = commit_sub ? ({hi_q, lo_q} - {commit_hi_data, commit_lo_data})
                             : ({hi_q, lo_q} + {commit_hi_data, commit_lo_data});
        if (commit_acc && commit_hi_en && commit_lo_en) begin
            {hi_cval, lo_cval} = acc_sum;
        end else begin
            hi_cval = commit_hi_data;
            lo_cval = commit_lo_data;
        end
    end
`else
    assign hi_cval = commit_hi_data;
    assign lo_cval = commit_lo_data;
`endif

    always_comb begin
        hi_d = commit_hi_en ? hi_cval : hi_q;
        lo_d = commit_lo_en ? lo_cval : lo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Walk oldest to youngest so stage 0 is the last, and therefore winning, assignment.
    always_comb begin
        hi_rdata = commit_hi_en ? hi_cval : hi_q;
        lo_rdata = commit_lo_en ? lo_cval : lo_q;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (fwd_hi_en[i]) hi_rdata = fwd_hi_data[`HILO_FWD_LSB(i, DATA_WIDTH) +: DATA_WIDTH];
            if (fwd_lo_en[i]) lo_rdata = fwd_lo_data[`HILO_FWD_LSB(i, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    hilo_pend_tracker #(
        .PEND_W (PEND_W)
    ) u_pend (
        .clk       (clk),
        .rst       (rst),
        .mdu_start (mdu_start),
        .mdu_done  (mdu_done),
        .flush     (flush),
        .pend_cnt  (pend_cnt),
        .pend_err  (pend_err)
    );

    assign stall_req = rd_req && (pend_cnt != '0);

endmodule

// File: tb/tb_hilo_bypass_file.sv
// Self-checking bench for hilo_bypass_file: per-cycle model compare plus directed literal checks.
module tb_hilo_bypass_file;

    localparam int DW   = 32;
    localparam int FS   = 2;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [FS-1:0]    fwd_hi_en, fwd_lo_en;
    logic [FS*DW-1:0] fwd_hi_data, fwd_lo_data;
    logic             commit_hi_en, commit_lo_en;
    logic [DW-1:0]    commit_hi_data, commit_lo_data;
    logic             commit_acc, commit_sub;
    logic             mdu_start, mdu_done, flush, rd_req;
    logic [DW-1:0]    hi_rdata, lo_rdata;
    logic             stall_req, pend_err;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [DW-1:0] m_hi, m_lo;
    int            m_pend;
    logic          m_err;

    hilo_bypass_file #(.DATA_WIDTH(DW), .FWD_STAGES(FS), .PEND_W(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fwd_hi_en      (fwd_hi_en),
        .fwd_lo_en      (fwd_lo_en),
        .fwd_hi_data    (fwd_hi_data),
        .fwd_lo_data    (fwd_lo_data),
        .commit_hi_en   (commit_hi_en),
        .commit_lo_en   (commit_lo_en),
        .commit_hi_data (commit_hi_data),
        .commit_lo_data (commit_lo_data),
`ifdef HILO_ACC_EN
        .commit_acc     (commit_acc),
        .commit_sub     (commit_sub),
`endif
        .mdu_start      (mdu_start),
        .mdu_done       (mdu_done),
        .flush          (flush),
        .rd_req         (rd_req),
        .hi_rdata       (hi_rdata),
        .lo_rdata       (lo_rdata),
        .stall_req      (stall_req),
        .pend_err       (pend_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value the commit port delivers this cycle, as {HI,LO}.
    function automatic logic [63:0] commit_value();
        logic [63:0] v;
        v = {commit_hi_data, commit_lo_data};
`ifdef HILO_ACC_EN
        if (commit_acc && commit_hi_en && commit_lo_en)
            v = commit_sub ? ({m_hi, m_lo} - v) : ({m_hi, m_lo} + v);
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        logic [63:0] cv;
        cv = commit_value();
        if (rst) begin
            m_hi = '0; m_lo = '0; m_pend = 0; m_err = 1'b0;
        end else begin
            if (commit_hi_en) m_hi = cv[63:32];
            if (commit_lo_en) m_lo = cv[31:0];
            if (flush) m_pend = 0;
            else if (mdu_start && !mdu_done) begin
                if (m_pend == PMAX) m_err = 1'b1; else m_pend = m_pend + 1;
            end else if (mdu_done && !mdu_start) begin
                if (m_pend == 0) m_err = 1'b1; else m_pend = m_pend - 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] cv;
        logic [DW-1:0] eh, el;
        bit fh, fl;
        if (!rst) begin
            cv = commit_value();
            eh = commit_hi_en ? cv[63:32] : m_hi;
            el = commit_lo_en ? cv[31:0]  : m_lo;
            fh = 0; fl = 0;
            for (int i = 0; i < FS; i++) begin
                if (!fh && fwd_hi_en[i]) begin eh = fwd_hi_data[i*DW +: DW]; fh = 1; end
                if (!fl && fwd_lo_en[i]) begin el = fwd_lo_data[i*DW +: DW]; fl = 1; end
            end
            chk("model_hi_rdata", 64'(hi_rdata), 64'(eh));
            chk("model_lo_rdata", 64'(lo_rdata), 64'(el));
            chk("model_stall_req", 64'(stall_req), 64'(rd_req && (m_pend != 0)));
            chk("model_pend_err", 64'(pend_err), 64'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; fwd_hi_en = '0; fwd_lo_en = '0; fwd_hi_data = '0; fwd_lo_data = '0;
        commit_hi_en = 0; commit_lo_en = 0; commit_hi_data = '0; commit_lo_data = '0;
        commit_acc = 0; commit_sub = 0; mdu_start = 0; mdu_done = 0; flush = 0; rd_req = 1;
        step(); step();
        rst = 0;

        // Reset state
        @(negedge clk);
        chk("rst_hi", 64'(hi_rdata), 64'h0);
        chk("rst_lo", 64'(lo_rdata), 64'h0);
        chk("rst_stall", 64'(stall_req), 64'h0);
        chk("rst_err", 64'(pend_err), 64'h0);
        step();

        // HI-only commit, with same-cycle bypass
        commit_hi_en = 1; commit_hi_data = 32'h1234_5678;
        @(negedge clk);
        chk("bypass_hi", 64'(hi_rdata), 64'h1234_5678);
        step();
        commit_hi_en = 0;
        @(negedge clk);
        chk("mthi_hi", 64'(hi_rdata), 64'h1234_5678);
        chk("mthi_lo", 64'(lo_rdata), 64'h0);
        step();

        // Forwarding priority
        commit_hi_en = 1; commit_hi_data = 32'h1;
        step();
        fwd_hi_en = 2'b11; fwd_hi_data = {32'hBBBB_0000, 32'hAAAA_0000};
        commit_hi_data = 32'hCCCC;
        @(negedge clk);
        chk("fwd_s0", 64'(hi_rdata), 64'hAAAA_0000);
        #1 fwd_hi_en = 2'b10;
        #1 chk("fwd_s1", 64'(hi_rdata), 64'hBBBB_0000);
        #1 fwd_hi_en = 2'b00;
        #1 chk("fwd_commit", 64'(hi_rdata), 64'hCCCC);
        step();
        commit_hi_en = 0;
        fwd_lo_en = 2'b10; fwd_lo_data = {32'h5555_AAAA, 32'h0};
        @(negedge clk);
        chk("reg_hi_cccc", 64'(hi_rdata), 64'hCCCC);
        chk("fwd_lo_s1", 64'(lo_rdata), 64'h5555_AAAA);
        step();
        fwd_lo_en = 2'b00;

        // MDU stall and release through commit
        mdu_start = 1;
        step();
        mdu_start = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mdu_stall", 64'(stall_req), 64'h1);
            step();
        end
        mdu_done = 1; commit_hi_en = 1; commit_lo_en = 1;
        commit_hi_data = 32'h2; commit_lo_data = 32'h3;
        @(negedge clk);
        chk("done_same_cycle_stall", 64'(stall_req), 64'h1);
        step();
        mdu_done = 0; commit_hi_en = 0; commit_lo_en = 0;
        @(negedge clk);
        chk("done_stall", 64'(stall_req), 64'h0);
        chk("done_hi", 64'(hi_rdata), 64'h2);
        chk("done_lo", 64'(lo_rdata), 64'h3);
        step();

        // Saturation, flush, underflow
        mdu_start = 1;
        repeat (4) step();
        mdu_start = 0;
        @(negedge clk);
        chk("sat_err", 64'(pend_err), 64'h1);
        mdu_done = 1;
        step(); step();
        mdu_done = 0;
        @(negedge clk);
        chk("sat_count_1", 64'(stall_req), 64'h1);
        flush = 1; mdu_start = 1;
        step();
        flush = 0; mdu_start = 0;
        @(negedge clk);
        chk("flush_stall", 64'(stall_req), 64'h0);
        chk("flush_keeps_hi", 64'(hi_rdata), 64'h2);
        mdu_done = 1;
        step();
        mdu_done = 0;
        @(negedge clk);
        chk("underflow_err", 64'(pend_err), 64'h1);
        chk("underflow_stall", 64'(stall_req), 64'h0);

        // Reset mid-operation
        mdu_start = 1;
        step();
        mdu_start = 0; rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("rst2_err", 64'(pend_err), 64'h0);
        chk("rst2_stall", 64'(stall_req), 64'h0);
        chk("rst2_hi", 64'(hi_rdata), 64'h0);
        step();

`ifdef HILO_ACC_EN
        commit_hi_en = 1; commit_lo_en = 1;
        commit_hi_data = 32'h0; commit_lo_data = 32'hFFFF_FFFF;
        step();
        commit_acc = 1; commit_lo_data = 32'h1;
        @(negedge clk);
        chk("acc_bypass_hi", 64'(hi_rdata), 64'h1);
        step();
        commit_sub = 1;
        @(negedge clk);
        chk("acc_reg_hi", 64'(dut.hi_q), 64'h1);
        chk("acc_reg_lo", 64'(dut.lo_q), 64'h0);
        step();
        commit_acc = 0; commit_sub = 0; commit_hi_en = 0; commit_lo_en = 0;
        @(negedge clk);
        chk("sub_hi", 64'(hi_rdata), 64'h0);
        chk("sub_lo", 64'(lo_rdata), 64'hFFFF_FFFF);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_bypass_file.md
Name: hilo_bypass_file

Overview:
- HI/LO special-register file for the MIPS core, with a parametrised forwarding network.
- Holds the architectural HI and LO registers and accepts writes from the writeback/commit stage.
- Resolves reads by priority over FWD_STAGES in-flight pipeline stages.
- Tracks outstanding multi-cycle MDU operations and raises a stall when a read would see stale HI/LO.
- Sits beside the decode/execute boundary; feeds MFHI/MFLO and the MDU accumulate path.

Parameters:
- DATA_WIDTH, 32, width of HI and of LO.
- FWD_STAGES, 2, number of forwarding sources; index 0 is the youngest stage.
- PEND_W, 2, pending-operation counter width; at most 2^PEND_W-1 outstanding MDU ops.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous active-high reset.
- fwd_hi_en  in  FWD_STAGES  per-stage HI write-intent.
- fwd_lo_en  in  FWD_STAGES  per-stage LO write-intent.
- fwd_hi_data  in  FWD_STAGES*DATA_WIDTH  packed HI data; stage i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- fwd_lo_data  in  FWD_STAGES*DATA_WIDTH  packed LO data, same packing.
- commit_hi_en  in  1  commit-stage HI write.
- commit_lo_en  in  1  commit-stage LO write.
- commit_hi_data  in  DATA_WIDTH  HI commit value.
- commit_lo_data  in  DATA_WIDTH  LO commit value.
- mdu_start  in  1  multi-cycle MDU op issued; it will write HI and LO.
- mdu_done  in  1  one MDU op has delivered its result to commit.
- flush  in  1  pipeline flush; discards outstanding MDU ops.
- rd_req  in  1  decode is reading HI or LO this cycle.
- hi_rdata  out  DATA_WIDTH  resolved HI value.
- lo_rdata  out  DATA_WIDTH  resolved LO value.
- stall_req  out  1  read must stall.
- pend_err  out  1  sticky protocol-error flag.

Behaviour:
- Single clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - HI and LO registers, the pending counter and pend_err all clear to 0.
  - stall_req is 0 after reset. hi_rdata and lo_rdata read 0 unless a forwarding or commit enable is active.
- Register update:
  - On a rising edge with rst=0, HI <= commit_hi_data when commit_hi_en=1. LO is updated the same way from commit_lo_data and commit_lo_en.
  - HI and LO are independent, so MTHI and MTLO each write a single half.
  - rst has priority over every commit.
- Read resolution is combinational with zero latency, and HI and LO resolve independently. Priority order:
  - fwd stage 0 (highest), then 1, through FWD_STAGES-1;
  - then the commit port;
  - then the architectural register.
- Same-cycle write and read: the read sees the commit value through the bypass, and the register updates on the edge.
- Pending counter:
  - Increments on mdu_start alone and decrements on mdu_done alone.
  - Unchanged when both are asserted in the same cycle.
- Pending boundaries:
  - mdu_start with the counter at maximum: the counter saturates and pend_err is set.
  - mdu_done with the counter at 0: the counter stays 0 and pend_err is set.
  - pend_err clears only on rst.
- flush:
  - Forces the counter to 0 on the next edge and overrides start and done in that cycle.
  - Does not touch HI or LO; commit is already past the flush point.
- stall_req = rd_req AND (counter != 0), combinational.
  - A done and a read in the same cycle still stall; the result becomes visible through commit on the next cycle's read.
- No other state. rst asserted mid-operation drops all pending state immediately.

Optional Feature:
- Macro: HILO_ACC_EN.
- When defined, two extra inputs are added: commit_acc (1 bit) and commit_sub (1 bit).
  - If commit_acc=1 with both commit enables set, {HI,LO} <= {HI,LO} + {commit_hi_data,commit_lo_data}, or minus when commit_sub=1.
  - Arithmetic is 2*DATA_WIDTH wide, modulo 2^(2*DATA_WIDTH); carry and borrow cross from LO into HI. This implements MADD/MADDU/MSUB/MSUBU.
  - The commit bypass forwards the accumulated sum, not the raw operand.
- When undefined, the ports are absent and commit is a plain write.

Decomposition:
- Shared package/header constants:
  - HILO_DATA_W default;
  - the forwarding-slice index macro;
  - the pending-counter max expression.
- One sub-module, hilo_pend_tracker: counter, saturation, flush and pend_err.
- Register file and priority mux stay in the top module.

Test Plan:
- Reset then rd_req=1, all enables 0 -> hi_rdata=0, lo_rdata=0, stall_req=0, pend_err=0.
- Commit HI=0x12345678 only, next cycle read -> hi_rdata=0x12345678, lo_rdata=0; LO unchanged.
- Register HI=0x1; fwd_hi_en=2'b11 with stage0=0xAAAA0000, stage1=0xBBBB0000; commit HI=0xCCCC -> hi_rdata=0xAAAA0000. Drop stage 0 -> 0xBBBB0000. Drop both -> 0xCCCC.
- mdu_start, then rd_req for 3 cycles -> stall_req=1. Assert mdu_done with commit {0x2,0x3} -> next cycle stall_req=0, hi_rdata=0x2, lo_rdata=0x3.
- Pending-counter sequence:
  - 4x mdu_start with PEND_W=2 -> counter saturates at 3 and pend_err=1.
  - flush -> counter 0; stall_req=0 with rd_req=1.
  - mdu_done at 0 -> pend_err stays 1.
- HILO_ACC_EN: HI,LO=0x0,0xFFFFFFFF; acc commit {0x0,0x1} -> HI=0x1, LO=0x0. Then commit_sub with {0x0,0x1} -> HI=0x0, LO=0xFFFFFFFF.
